// File: rtl/pci_multi_queue_pkg.sv
// Shared types for the multi-lane fetch queue: instruction record, flush request and NOP filler.
package pci_multi_queue_pkg;

  typedef enum logic [6:0] {
    op_lui = 7'b0110111,
    op_imm = 7'b0010011,
    op_reg = 7'b0110011,
    op_br  = 7'b1100011
  } opcode_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    opcode_t     opcode;
  } pci_t;

  typedef struct packed {
    logic valid;
  } flush_t;

  // Empty slots always hold an addi x0,x0,0-shaped record so decode sees a harmless op.
  localparam pci_t PCI_NOP = '{pc: 32'h0, instr: 32'h0, opcode: op_imm};

endpackage

// File: rtl/pci_multi_queue_if.sv
// Fetch-side and decode-side handshake bundle for pci_multi_queue.
interface pci_multi_queue_if
  import pci_multi_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DEQ_W + 1);

  flush_t                 flush;
  logic [ENQ_W-1:0]       enq_valid;
  pci_t [ENQ_W-1:0]       enq_data;
  logic                   enq_ready;
  logic [DW-1:0]          deq_num;
  pci_t [DEQ_W-1:0]       deq_data;
  logic [DEQ_W-1:0]       deq_valid;
  logic [CW-1:0]          count;
  logic                   empty;
  logic                   full;

  modport master (
    output flush, enq_valid, enq_data, deq_num,
    input  enq_ready, deq_data, deq_valid, count, empty, full
  );

  modport slave (
    input  flush, enq_valid, enq_data, deq_num,
    output enq_ready, deq_data, deq_valid, count, empty, full
  );

endinterface

// File: rtl/pci_multi_queue_popcount.sv
// Counts set bits of a lane-valid mask.
module pci_multi_queue_popcount #(
  parameter int W = 2
) (
  input  logic [W-1:0]             mask_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);
  localparam int CW = $clog2(W + 1);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(mask_i[i]);
    end
  end

endmodule

// File: rtl/pci_multi_queue.sv
// Circular fetch queue: all-or-nothing group enqueue, clamped partial dequeue, priority flush.
module pci_multi_queue
  import pci_multi_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  pci_multi_queue_if.slave    q_if
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $clog2(ENQ_W + 1);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  pci_t          arr_q [DEPTH];
  pci_t          arr_d [DEPTH];

  logic [EW-1:0] n_enq;
  logic [CW-1:0] n_enq_acc, n_deq;
  logic          enq_ready, enq_acc;

  pci_multi_queue_popcount #(.W(ENQ_W)) u_popcount (
    .mask_i (q_if.enq_valid),
    .cnt_o  (n_enq)
  );

  // Ready looks only at registered occupancy, so it never depends on this cycle's dequeue.
  assign enq_ready = (CW'(DEPTH) - count_q) >= CW'(ENQ_W);
  assign enq_acc   = enq_ready && (n_enq != '0);
  assign n_enq_acc = enq_acc ? CW'(n_enq) : '0;

  always_comb begin
    n_deq = CW'(q_if.deq_num);
    if (n_deq > count_q)       n_deq = count_q;
    if (n_deq > CW'(DEQ_W))    n_deq = CW'(DEQ_W);
  end

  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    head_d  = head_q + PW'(n_deq);
    tail_d  = tail_q + PW'(n_enq_acc);
    count_d = count_q + n_enq_acc - n_deq;
    arr_d   = arr_q;
    for (int i = 0; i < DEQ_W; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < n_deq) arr_d[idx] = PCI_NOP;
    end
    // Writes follow the clears so a new entry always survives an index overlap.
    for (int i = 0; i < ENQ_W; i++) begin
      idx = tail_q + PW'(i);
      if (enq_acc && q_if.enq_valid[i]) arr_d[idx] = q_if.enq_data[i];
    end
    if (q_if.flush.valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) arr_d[i] = PCI_NOP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) arr_q[i] <= PCI_NOP;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      arr_q   <= arr_d;
    end
  end

  always_comb begin
    logic [PW-1:0] ridx;
    ridx           = '0;
    q_if.deq_valid = '0;
    q_if.deq_data  = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      ridx              = head_q + PW'(i);
      q_if.deq_valid[i] = CW'(i) < count_q;
      q_if.deq_data[i]  = (CW'(i) < count_q) ? arr_q[ridx] : PCI_NOP;
    end
  end

  assign q_if.enq_ready = enq_ready;
  assign q_if.count     = count_q;
  assign q_if.empty     = (count_q == '0);
  assign q_if.full      = (count_q == CW'(DEPTH));

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(DEPTH));
  a_ptr_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
    PW'(tail_q - head_q) == count_q[PW-1:0]);
  a_prefix_mask: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (q_if.enq_valid & (q_if.enq_valid + 1'b1)) == '0);

endmodule

// File: tb/tb_pci_multi_queue.sv
// Directed plus randomized check of pci_multi_queue against a queue-based reference model.
module tb_pci_multi_queue;
  import pci_multi_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DW    = $clog2(DEQ_W + 1);

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  pci_multi_queue_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) q_if ();

  pci_multi_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .q_if   (q_if.slave)
  );

  pci_t        model [$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] pc_ctr      = 32'h100;

  function automatic pci_t nop();
    pci_t n;
    n.pc     = 32'h0;
    n.instr  = 32'h0;
    n.opcode = op_imm;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int   sz;
    pci_t e;
    sz = model.size();
    chk({tag, ".count"},     128'(q_if.count),     128'(sz));
    chk({tag, ".empty"},     128'(q_if.empty),     128'(sz == 0));
    chk({tag, ".full"},      128'(q_if.full),      128'(sz == DEPTH));
    chk({tag, ".enq_ready"}, 128'(q_if.enq_ready), 128'((DEPTH - sz) >= ENQ_W));
    for (int i = 0; i < DEQ_W; i++) begin
      e = (i < sz) ? model[i] : nop();
      chk($sformatf("%s.out_valid%0d", tag, i), 128'(q_if.deq_valid[i]), 128'(i < sz));
      chk($sformatf("%s.out%0d", tag, i),       128'(q_if.deq_data[i]),  128'(e));
    end
  endtask

  task automatic idle();
    q_if.flush.valid = 1'b0;
    q_if.enq_valid   = '0;
    q_if.enq_data    = '0;
    q_if.deq_num     = '0;
  endtask

  // Checks the state left by the previous edge, then applies one cycle of stimulus.
  task automatic step(input string tag, input bit fl, input int n_lanes, input int deq, input bit rnd);
    pci_t din [ENQ_W];
    int   nd;
    bit   rdy;
    check_outputs(tag);
    for (int i = 0; i < ENQ_W; i++) begin
      din[i].pc    = (i < n_lanes) ? pc_ctr : $urandom;
      din[i].instr = rnd ? $urandom : 32'h0;
      case ($urandom_range(0, 3))
        0:       din[i].opcode = op_lui;
        1:       din[i].opcode = op_imm;
        2:       din[i].opcode = op_reg;
        default: din[i].opcode = op_br;
      endcase
      if (i < n_lanes) pc_ctr = pc_ctr + 32'd4;
      q_if.enq_valid[i] = (i < n_lanes);
      q_if.enq_data[i]  = din[i];
    end
    q_if.flush.valid = fl;
    q_if.deq_num     = DW'(deq);
    @(posedge clk_i);
    if (fl) begin
      model.delete();
    end else begin
      rdy = (DEPTH - model.size()) >= ENQ_W;
      nd  = deq;
      if (nd > model.size()) nd = model.size();
      if (nd > DEQ_W)        nd = DEQ_W;
      for (int k = 0; k < nd; k++) void'(model.pop_front());
      if (rdy && n_lanes > 0)
        for (int k = 0; k < n_lanes; k++) model.push_back(din[k]);
    end
    #1;
  endtask

  initial begin
    idle();
    #3;
    check_outputs("reset");
    #9 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    step("p1_enq", 0, 2, 0, 0);
    step("p1_vis", 0, 2, 0, 0);
    step("p2_fill", 0, 2, 0, 0);
    step("p2_fill7", 0, 1, 0, 0);
    step("p2_drop7", 0, 1, 0, 0);
    step("p2_drop", 0, 2, 0, 0);
    step("p3_deq", 0, 0, 2, 0);
    step("p3_wrap", 0, 2, 2, 0);
    step("p3_wrap", 0, 2, 2, 0);
    step("p3_wrap", 0, 2, 2, 0);
    step("p3_deq4", 0, 0, 2, 0);
    step("p4_drain", 0, 0, 3, 0);
    step("p4_drain1", 0, 0, 1, 0);
    step("p4_clamp", 0, 0, 2, 0);
    step("p4_empty", 0, 2, 0, 0);
    step("p5_fill3", 0, 1, 0, 0);
    step("p5_swap", 0, 2, 2, 0);
    step("p5_chk", 0, 2, 1, 0);
    step("p6_flush", 1, 2, 2, 0);
    step("p6_after", 0, 2, 0, 0);
    step("p6_more", 0, 1, 0, 0);
    idle();
    #3 rst_ni = 1'b0;
    #1 model.delete();
    check_outputs("p6_async_rst");
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int c = 0; c < 400; c++) begin
      step("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, ENQ_W),
           $urandom_range(0, (1 << DW) - 1), 1);
    end
    idle();
    @(posedge clk_i);
    #1;
    check_outputs("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
